rgd_arbiter_n: RTL and testbench
================================

Name: rgd_arbiter_n

Overview:
- Parametrised, clocked N-channel Request-Grant-Done arbiter.
- Each client runs a 4-phase handshake: raise req, receive gnt, use the resource, raise done, see gnt drop, then lower req and done.
- Guards one shared resource among up to 16 asynchronous-style clients that have already been synchronised into the clk domain.
- Successor to the 2-channel RGD arbiter: adds channel count, selectable fixed or round-robin priority, an owner index output and protocol-error detection.

Parameters:
- N, 4, number of client channels (2..16).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (channel 0 highest).
- IDW, 2, width of gnt_id; must satisfy 2**IDW >= N.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-channel request, level, already synchronised.
- done  input  N  per-channel done, level, already synchronised.
- gnt  output  N  per-channel grant, one-hot or zero, registered.
- gnt_id  output  IDW  index of current or last owner, registered.
- busy  output  1  high while FSM is not IDLE.
- err  output  1  sticky protocol-error flag; cleared only by rst.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values (rst high at a clk edge): gnt=0, gnt_id=0, busy=0, err=0, state=IDLE, rr pointer=0. rst overrides any in-progress handshake: gnt drops the cycle after rst is sampled, and no RELEASE is waited for.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, pick winner w; next cycle gnt[w]=1, gnt_id=w, state=GRANT.
  - Grant latency: 1 clk from the sampled req.
  - If req == 0, stay in IDLE.
- Winner selection:
  - RR=0: lowest-index asserted req.
  - RR=1: first asserted req at or after ptr, scanning upward and wrapping N-1 to 0.
  - On grant, ptr <= (w+1) mod N. ptr wraps from N-1 to 0.
- GRANT:
  - If done[w]=1: gnt <= 0, state=RELEASE.
  - If req[w]=0 before done[w] (withdrawal/abort): gnt <= 0, state=RELEASE.
  - Requests from other channels are ignored but remain pending.
- RELEASE:
  - Wait until req[w]=0 and done[w]=0, then go to IDLE.
  - A new arbitration can be sampled on the following cycle. Minimum turnaround from done to the next gnt is 3 clk.
- busy = (state != IDLE), registered alongside state.
- gnt_id holds the last owner in IDLE; it is not cleared.
- err sets (sticky) on any of:
  - done[i]=1 while req[i]=0, in any state;
  - done[i]=1 for i != w while in GRANT or RELEASE;
  - done[i]=1 while in IDLE.
  - err never affects arbitration.
- Simultaneous requests in the same IDLE cycle: exactly one grant, chosen per mode. Losers remain pending and are never dropped.
- Channels >= N do not exist; IDW upper codes are unused.
- Invariants:
  - popcount(gnt) <= 1 at all times.
  - gnt[i]=1 implies state=GRANT and gnt_id=i.
  - No grant while in RELEASE.

Test Plan:
- Reset, N=4, RR=1: hold rst 2 cycles with req=4'b1111 → gnt=0, busy=0, err=0 throughout. First rst-low edge then grants ch0 (gnt=4'b0001, gnt_id=0) one cycle later.
- Round-robin fairness, N=4, RR=1: req=4'b1111 held, each grantee completes done → grant order 0,1,2,3,0. Each gnt is followed by gnt drop 1 clk after done, and there is ≥3 clk between successive grants.
- Fixed priority, RR=0: req=4'b1010 held, each client completing in turn → ch1 always wins. ch3 is granted only after ch1 drops req.
- Abort: ch2 granted, then req[2] falls with done[2]=0 → gnt=0 next clk, state RELEASE then IDLE, err=0, pending ch0 granted afterwards.
- Protocol error: ch1 owns the grant, and done[3] pulses for 1 clk → err=1 and stays 1. The ch1 handshake completes normally, and err clears only on rst.
- Reset mid-grant: assert rst while gnt[2]=1 → gnt=0, busy=0, ptr=0 on the next cycle. With req=4'b0100 still high, ch2 is re-granted after rst falls.

Source files
------------

// File: rtl/rgd_arbiter_n.sv
// N-channel Request-Grant-Done arbiter guarding one shared resource.
// Fixed or round-robin priority, registered one-hot grant, owner index and sticky protocol-error flag.
//
// state   | meaning
// IDLE    | no owner; arbitrate among pending requests
// GRANT   | gnt[owner] high; waiting for done or request withdrawal
// RELEASE | grant dropped; waiting for the owner's req and done to fall
module rgd_arbiter_n #(
    parameter int N   = 4,
    parameter bit RR  = 1'b1,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic [N-1:0]   hi_mask;
    logic [N-1:0]   req_hi;
    logic [N-1:0]   cand;
    logic [N-1:0]   win_mask;
    logic [IDW-1:0] win_id;
    logic           win_vld;
    logic [N-1:0]   own_mask;
    logic           own_req;
    logic           own_done;
    logic           err_hit;

    // Round-robin: prefer requests at or above the pointer, otherwise wrap to the lowest one.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (IDW'(i) >= ptr_q);
        end
        req_hi = req & hi_mask;
        if (RR && (req_hi != '0)) begin
            cand = req_hi;
        end else begin
            cand = req;
        end
    end

    always_comb begin
        win_id  = '0;
        win_vld = (cand != '0);
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id = IDW'(i);
            end
        end
        win_mask = '0;
        for (int i = 0; i < N; i++) begin
            win_mask[i] = (win_id == IDW'(i));
        end
    end

    always_comb begin
        own_mask = '0;
        for (int i = 0; i < N; i++) begin
            own_mask[i] = (id_q == IDW'(i));
        end
        own_req  = |(req & own_mask);
        own_done = |(done & own_mask);
    end

    // In IDLE no channel may signal done; otherwise only the owner may.
    always_comb begin
        err_hit = |(done & ~req);
        if (state_q == IDLE) begin
            err_hit = err_hit | (|done);
        end else begin
            err_hit = err_hit | (|(done & ~own_mask));
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    gnt_d   = win_mask;
                    id_d    = win_id;
                    if (win_id == IDW'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_id + IDW'(1);
                    end
                end
            end
            GRANT: begin
                if (own_done || !own_req) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end
            end
            RELEASE: begin
                gnt_d = '0;
                if (!own_req && !own_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
        err_d  = err_q | err_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_rgd_arbiter_n.sv
// Bench for rgd_arbiter_n: a round-robin and a fixed-priority instance checked every cycle
// against a handshake-level model, plus directed literal expectations.
module tb_rgd_arbiter_n;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_a = '0, done_a = '0, req_b = '0, done_b = '0;
    logic [N-1:0] gnt_a, gnt_b;
    logic [1:0]   id_a, id_b;
    logic         busy_a, busy_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgd_arbiter_n #(.N(N), .RR(1'b1), .IDW(2)) u_rr (
        .clk(clk), .rst(rst), .req(req_a), .done(done_a),
        .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a), .err(err_a)
    );

    rgd_arbiter_n #(.N(N), .RR(1'b0), .IDW(2)) u_fp (
        .clk(clk), .rst(rst), .req(req_b), .done(done_b),
        .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b), .err(err_b)
    );

    // Model: who owns the resource, whether it is still granted or being released.
    int           m_phase [2] = '{0, 0};
    int           m_owner [2] = '{0, 0};
    int           m_next  [2] = '{0, 0};
    logic [N-1:0] m_gnt   [2] = '{'0, '0};
    bit           m_err   [2] = '{0, 0};

    task automatic model_step(input int m, input bit rr, input logic [N-1:0] rq, input logic [N-1:0] dn);
        if (rst) begin
            m_phase[m] = 0; m_owner[m] = 0; m_next[m] = 0; m_gnt[m] = '0; m_err[m] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (dn[i] && (!rq[i] || m_phase[m] == 0 || i != m_owner[m])) m_err[m] = 1;
            if (m_phase[m] == 0) begin
                if (rq != '0) begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = rr ? (m_next[m] + k) % N : k;
                        if (rq[c]) begin
                            m_owner[m] = c;
                            m_gnt[m] = '0;
                            m_gnt[m][c] = 1'b1;
                            m_next[m] = (c + 1) % N;
                            m_phase[m] = 1;
                            break;
                        end
                    end
                end
            end else if (m_phase[m] == 1) begin
                if (dn[m_owner[m]] || !rq[m_owner[m]]) begin
                    m_gnt[m] = '0;
                    m_phase[m] = 2;
                end
            end else begin
                if (!rq[m_owner[m]] && !dn[m_owner[m]]) m_phase[m] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 1'b1, req_a, done_a);
        model_step(1, 1'b0, req_b, done_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_gnt_rr",  32'(gnt_a),  32'(m_gnt[0]));
        chk("model_id_rr",   32'(id_a),   32'(m_owner[0]));
        chk("model_busy_rr", 32'(busy_a), 32'(m_phase[0] != 0));
        chk("model_err_rr",  32'(err_a),  32'(m_err[0]));
        chk("model_gnt_fp",  32'(gnt_b),  32'(m_gnt[1]));
        chk("model_id_fp",   32'(id_b),   32'(m_owner[1]));
        chk("model_busy_fp", 32'(busy_b), 32'(m_phase[1] != 0));
        chk("model_err_fp",  32'(err_b),  32'(m_err[1]));
    end

    function automatic logic [N-1:0] gnt_of(input int inst);
        return (inst == 0) ? gnt_a : gnt_b;
    endfunction

    task automatic set_sig(input int inst, input bit is_done, input int ch, input logic v);
        if (inst == 0) begin
            if (is_done) done_a[ch] = v; else req_a[ch] = v;
        end else begin
            if (is_done) done_b[ch] = v; else req_b[ch] = v;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input int inst, output int cycles);
        cycles = 0;
        while (gnt_of(inst) == '0 && cycles < 20) begin
            tick();
            cycles++;
        end
        if (cycles >= 20) begin
            checks++;
            errors++;
            $display("FAIL wait_gnt inst=%0d no grant within %0d cycles", inst, cycles);
        end
    endtask

    // Owner completes: done high, see gnt drop, lower req and done, optionally re-request.
    task automatic serve(input int inst, input int ch, input bit reraise);
        set_sig(inst, 1'b1, ch, 1'b1);
        tick();
        chk("gnt_drop_after_done", 32'(gnt_of(inst)), 32'h0);
        set_sig(inst, 1'b1, ch, 1'b0);
        set_sig(inst, 1'b0, ch, 1'b0);
        tick();
        if (reraise) set_sig(inst, 1'b0, ch, 1'b1);
    endtask

    initial begin
        int cyc;
        int order [5] = '{0, 1, 2, 3, 0};

        // Reset held with all requests pending
        rst = 1'b1;
        req_a = 4'b1111;
        tick();
        chk("rst_gnt_1", 32'(gnt_a), 32'h0);
        chk("rst_busy_1", 32'(busy_a), 32'h0);
        tick();
        chk("rst_gnt_2", 32'(gnt_a), 32'h0);
        chk("rst_err_2", 32'(err_a), 32'h0);
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt_a), 32'h1);
        chk("first_id", 32'(id_a), 32'h0);

        // Round-robin order with all four clients permanently requesting
        for (int g = 0; g < 5; g++) begin
            if (g > 0) begin
                wait_gnt(0, cyc);
                chk("rr_turnaround", 32'(cyc + 2), 32'd3);
            end
            chk("rr_order_gnt", 32'(gnt_a), 32'(1 << order[g]));
            chk("rr_order_id", 32'(id_a), 32'(order[g]));
            serve(0, order[g], 1'b1);
        end

        // Fixed priority: ch1 keeps winning until it stops requesting
        req_b = 4'b1010;
        wait_gnt(1, cyc);
        chk("fp_gnt_1", 32'(gnt_b), 32'h2);
        serve(1, 1, 1'b1);
        wait_gnt(1, cyc);
        chk("fp_gnt_1_again", 32'(gnt_b), 32'h2);
        serve(1, 1, 1'b0);
        wait_gnt(1, cyc);
        chk("fp_gnt_3", 32'(gnt_b), 32'h8);
        chk("fp_id_3", 32'(id_b), 32'h3);
        serve(1, 3, 1'b0);

        // Abort: ch2 withdraws its request before done
        rst = 1'b1;
        req_a = '0;
        done_a = '0;
        tick(2);
        rst = 1'b0;
        req_a = 4'b0100;
        tick();
        chk("abort_gnt_2", 32'(gnt_a), 32'h4);
        req_a[0] = 1'b1;
        tick();
        req_a[2] = 1'b0;
        tick();
        chk("abort_gnt_drop", 32'(gnt_a), 32'h0);
        chk("abort_busy_release", 32'(busy_a), 32'h1);
        tick();
        chk("abort_idle", 32'(busy_a), 32'h0);
        wait_gnt(0, cyc);
        chk("abort_then_ch0", 32'(gnt_a), 32'h1);
        chk("abort_err", 32'(err_a), 32'h0);
        serve(0, 0, 1'b0);

        // Stray done from a non-owner sets the sticky error
        req_a = 4'b0010;
        wait_gnt(0, cyc);
        chk("perr_gnt_1", 32'(gnt_a), 32'h2);
        done_a[3] = 1'b1;
        tick();
        done_a[3] = 1'b0;
        chk("perr_err_set", 32'(err_a), 32'h1);
        chk("perr_gnt_kept", 32'(gnt_a), 32'h2);
        serve(0, 1, 1'b0);
        tick();
        chk("perr_err_sticky", 32'(err_a), 32'h1);
        chk("perr_idle", 32'(busy_a), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("perr_err_cleared", 32'(err_a), 32'h0);

        // Reset while ch2 holds the grant
        req_a = 4'b0100;
        wait_gnt(0, cyc);
        chk("midrst_gnt_2", 32'(gnt_a), 32'h4);
        rst = 1'b1;
        tick();
        chk("midrst_gnt_0", 32'(gnt_a), 32'h0);
        chk("midrst_busy_0", 32'(busy_a), 32'h0);
        rst = 1'b0;
        tick();
        chk("midrst_regrant", 32'(gnt_a), 32'h4);
        chk("midrst_regrant_id", 32'(id_a), 32'h2);
        serve(0, 2, 1'b0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
